// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers
// Optional feature macro: MDU_EARLY_TERM_EN (early multiply exit on an exhausted multiplier)
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   lsr_q, lsr_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               op_div_q, op_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               b_is_zero;
  logic               early_exit;
  logic               run_last;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign a_mag     = (op[0] && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (op[0] && b[WIDTH-1]) ? -b : b;
  assign b_is_zero = (b == '0);

`ifdef MDU_EARLY_TERM_EN
  // Multiplier bits not yet consumed sit in the low cnt_q bits of lsr_q.
  logic [WIDTH-1:0] run_mask;
  assign run_mask   = ~({WIDTH{1'b1}} << cnt_q);
  assign early_exit = !op_div_q && ((lsr_q & run_mask) == '0);
`else
  assign early_exit = 1'b0;
`endif

  assign run_last = early_exit || (cnt_q == CNT_W'(1));

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (op[1] && b_is_zero) ? S_DONE : S_RUN;
      S_RUN:  if (abort) state_d = S_IDLE;
              else if (run_last) state_d = S_FIX;
      S_FIX:  state_d = abort ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    lsr_d      = lsr_q;
    mcand_d    = mcand_q;
    op_div_d   = op_div_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    prod = {acc_q, lsr_q};
`ifdef MDU_EARLY_TERM_EN
    prod = prod >> cnt_q;
`endif
    prod_fix  = neg_q ? -prod : prod;
    mul_sum   = {1'b0, acc_q} + (lsr_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {acc_q, lsr_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mcand_q});

    case (state_q)
      S_IDLE: if (start) begin
        op_div_d   = op[1];
        neg_d      = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
        rneg_d     = op[0] & a[WIDTH-1];
        acc_d      = '0;
        mcand_d    = op[1] ? b_mag : a_mag;
        lsr_d      = op[1] ? a_mag : b_mag;
        cnt_d      = CNT_W'(WIDTH);
        div_zero_d = 1'b0;
        if (op[1] && b_is_zero) begin
          hi_d       = a;
          lo_d       = '1;
          div_zero_d = 1'b1;
          cnt_d      = '0;
        end
      end
      S_RUN: if (!early_exit) begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_div_q) begin
          acc_d = div_ge ? WIDTH'(div_shift - {1'b0, mcand_q}) : div_shift[WIDTH-1:0];
          lsr_d = {lsr_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          lsr_d = {mul_sum[0], lsr_q[WIDTH-1:1]};
        end
      end
      S_FIX: if (!abort) begin
        if (op_div_q) begin
          lo_d = neg_q  ? -lsr_q : lsr_q;
          hi_d = rneg_q ? -acc_q : acc_q;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      lsr_q      <= '0;
      mcand_q    <= '0;
      op_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      lsr_q      <= lsr_d;
      mcand_q    <= mcand_d;
      op_div_q   <= op_div_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;
endmodule
